// File: rtl/fetch_stage.sv
// Instruction fetch stage and IF/ID register: owns the PC, talks to a
// variable-latency instruction memory, and rides out stalls with a skid slot.
//
// Ports:
//   clk         clock, all state on rising edge
//   rst         synchronous active-low reset
//   stall       hazard unit asks to hold IF/ID
//   redirect    execute redirect (taken branch/jump/return)
//   redirectPc  redirect target, valid with redirect
//   imemReq     fetch request (level, combinational)
//   imemAddr    fetch address (= PC)
//   imemData    fetched word, valid with imemDone
//   imemDone    memory completes the request this cycle
//   instrOut    IF/ID instruction
//   nextPcOut   IF/ID PC+2 of instrOut
//   validOut    instrOut is real (0 = bubble)
//   err         sticky error flag
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirectPc,
  output logic        imemReq,
  output logic [15:0] imemAddr,
  input  logic [15:0] imemData,
  input  logic        imemDone,
  output logic [15:0] instrOut,
  output logic [15:0] nextPcOut,
  output logic        validOut,
  output logic        err
);

  localparam logic [0:0]  FETCH  = 1'b0;
  localparam logic [0:0]  HALTED = 1'b1;
  localparam logic [15:0] NOP    = 16'h0800;

  logic [0:0]  state;
  logic [15:0] pc;
  logic [15:0] pc_inc;
  logic [15:0] buf_instr;
  logic [15:0] buf_npc;
  logic        buf_valid;

  logic        accept;
  logic        is_halt;
  logic        spurious;
  logic        hold;
  logic        run;

  always_comb begin
    imemReq  = (state == FETCH) & ~buf_valid & ~redirect;
    imemAddr = pc;
    pc_inc   = pc + 16'd2;
    accept   = imemReq & imemDone;
    is_halt  = (imemData[15:11] == 5'b00000);
    // A completion nobody asked for; a redirect cycle drops it silently.
    spurious = imemDone & ~imemReq & ~redirect;
    hold     = stall & ~redirect;
    run      = ~stall & ~redirect;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= 16'h0000;
    end else if (redirect) begin
      pc <= {redirectPc[15:1], 1'b0};
    end else if (accept) begin
      pc <= pc_inc;
    end
  end

  // The halt may sit on a squashed path, so only
  // reset or redirect return to FETCH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FETCH;
    end else if (redirect) begin
      state <= FETCH;
    end else if (accept & is_halt) begin
      state <= HALTED;
    end
  end

  // Skid slot: fills only while stalled; requests
  // are blocked while it is full, so depth 1 is enough.
  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_instr <= NOP;
      buf_npc   <= 16'h0000;
    end else begin
      unique case (1'b1)
        redirect: begin
          buf_valid <= 1'b0;
        end
        hold: begin
          if (accept) begin
            buf_instr <= imemData;
            buf_npc   <= pc_inc;
            buf_valid <= 1'b1;
          end
        end
        run: begin
          buf_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      instrOut  <= NOP;
      nextPcOut <= 16'h0000;
      validOut  <= 1'b0;
    end else begin
      unique case (1'b1)
        redirect: begin
          instrOut <= NOP;
          validOut <= 1'b0;
        end
        hold: begin
        end
        run: begin
          if (buf_valid) begin
            instrOut  <= buf_instr;
            nextPcOut <= buf_npc;
            validOut  <= 1'b1;
          end else if (accept) begin
            instrOut  <= imemData;
            nextPcOut <= pc_inc;
            validOut  <= 1'b1;
          end else begin
            instrOut <= NOP;
            validOut <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err <= 1'b0;
    end else if ((redirect & redirectPc[0]) | spurious) begin
      err <= 1'b1;
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage pipeline. It sits directly upstream of the decode stage and drives its `instrIn`/`nextPcIn` from registered outputs. It owns the PC, sequences requests to a variable-latency instruction memory, and absorbs hazard-unit stalls with a one-entry skid buffer. It applies branch/jump redirects from execute and stops fetching after a halt.

## Interface
- No parameters. Width fixed at 16 bits; NOP = 16'h0800; HALT opcode = instr[15:11] == 5'b00000.
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- stall  in  1  hazard unit: hold IF/ID contents
- redirect  in  1  execute: taken branch/jump/return; flush and refetch
- redirectPc  in  16  target PC, valid with redirect
- imemReq  out  1  fetch request, level; combinational from state
- imemAddr  out  16  fetch address (= PC)
- imemData  in  16  instruction word, valid when imemDone
- imemDone  in  1  memory completes the request this cycle; same-cycle completion allowed
- instrOut  out  16  IF/ID instruction to decode
- nextPcOut  out  16  IF/ID PC+2 of instrOut
- validOut  out  1  instrOut is a real fetched instruction; 0 = bubble
- err  out  1  sticky error flag

## Operation
- State is held in PC[15:0], FSM {FETCH, HALTED}, skid buffer (bufInstr, bufNpc, bufValid), the IF/ID register, and err.
- imemReq = (state==FETCH) & !bufValid & !redirect. imemAddr = PC.
- Accept means imemReq & imemDone. The instruction is imemData and its npc is PC+2, computed modulo 2^16 (16'hFFFE wraps to 16'h0000).
- Per-cycle priority: reset > redirect > stall > normal.
- Reset (rst==0): PC=0, state=FETCH, bufValid=0, instrOut=16'h0800, nextPcOut=0, validOut=0, err=0.
- Redirect:
  - PC <= {redirectPc[15:1],1'b0}; state <= FETCH.
  - bufValid <= 0.
  - IF/ID <= NOP, nextPcOut unchanged, validOut=0.
  - imemDone in this cycle is ignored.
  - If redirectPc[0]=1, err <= 1.
  - Redirect overrides stall and HALTED.
- Stall, no redirect:
  - IF/ID holds.
  - On accept, the instruction goes into the buffer (bufValid<=1) and PC <= PC+2.
  - A further accept cannot occur while bufValid=1.
- Normal, no stall:
  - If bufValid: IF/ID <= buffer, validOut=1, bufValid<=0. No request this cycle.
  - Else on accept: IF/ID <= {imemData, PC+2}, validOut=1, PC <= PC+2.
  - Else: IF/ID <= NOP, validOut=0 (bubble).
- Halt: when a HALT word is accepted (into IF/ID or the buffer), state <= HALTED and PC stays at PC+2. In HALTED:
  - imemReq=0.
  - A buffered instruction still drains normally.
  - Subsequent unstalled cycles insert bubbles.
  - Only reset or redirect leave HALTED, because the halt may be on a squashed path.
- Protocol error: imemDone while imemReq==0 and no redirect sets err <= 1; the data is discarded. err clears only on reset.

## Timing
- Latency: accept in cycle N with no stall gives instrOut/validOut at N+1.
- With single-cycle memory (imemDone tied high), throughput is 1 instruction/cycle.
- Stall release: the buffered instruction appears one cycle after stall falls. The next memory request issues in that same cycle; the first post-buffer instruction appears no earlier than 2 cycles after stall falls.
- Redirect in cycle N: bubble at N+1; fetch of the target issues in N+1; the target instruction appears at N+2 at the earliest.
- A stall longer than one accept costs no extra memory traffic; the buffer depth of 1 is sufficient because requests block while bufValid=1.
- Reset mid-request: the request is abandoned, imemReq resumes in the first cycle after rst returns high, and imemAddr=0 in that cycle.

## Test plan
- Reset, then imemDone=1 returning 16'h4001/16'h4002/16'h4003 -> instrOut sequence 4001,4002,4003 on consecutive cycles, nextPcOut 2,4,6, validOut=1 from the second cycle after reset release.
- Stall held 3 cycles during an accept at PC=4 -> IF/ID frozen, exactly one accept while stalled, PC=6, imemReq=0 while buffered. On release the buffered word appears with nextPcOut=6, then a fetch at addr 6.
- Redirect to 16'h0100 coincident with stall and imemDone -> data dropped, next cycle validOut=0 with instrOut=0800, imemAddr=0100, err=0. Redirect to 16'h0101 -> imemAddr=0100, err=1 sticky.
- HALT word 16'h0000 accepted at PC=8 -> validOut=1 for the halt, then imemReq=0 and bubbles indefinitely. A redirect to 0x20 resumes fetching at 0x20.
- Memory latency 3 cycles (imemDone every third cycle) -> one bubble (validOut=0, instrOut=0800) for each cycle without an accept, no duplicated or lost instructions.
- PC=16'hFFFE accept -> nextPcOut=0, next imemAddr=0. Spurious imemDone with imemReq=0 -> err=1, IF/ID unchanged.
